// File: rtl/std_pkg.sv
// Shared types and constants for the std_* building blocks.
package std_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } std_flow_state_t;

   // Clocking/reset flavour of a storage element.
   typedef struct packed {
      logic rising_edge;
      logic async_reset;
      logic active_low;
   } std_clock_info_t;

   localparam std_clock_info_t STD_CLOCK_INFO_ASYNC_LOW = '{
      rising_edge: 1'b1,
      async_reset: 1'b1,
      active_low:  1'b1
   };

endpackage

// File: rtl/std_register.sv
// Generic enabled register of type T; clock edge and reset style chosen by CLK_INFO.
module std_register
   import std_pkg::*;
#(
   parameter type             T           = logic,
   parameter std_clock_info_t CLK_INFO    = STD_CLOCK_INFO_ASYNC_LOW,
   parameter T                RESET_VALUE = T'(0)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  T     d,
   output T     q
);

   logic clk_eff;

   assign clk_eff = CLK_INFO.rising_edge ? clk : ~clk;

   generate
      if (CLK_INFO.async_reset && CLK_INFO.active_low) begin : g_async_low
         always_ff @(posedge clk_eff or negedge rst) begin
            if (!rst)    q <= RESET_VALUE;
            else if (en) q <= d;
         end
      end else if (CLK_INFO.async_reset) begin : g_async_high
         always_ff @(posedge clk_eff or posedge rst) begin
            if (rst)     q <= RESET_VALUE;
            else if (en) q <= d;
         end
      end else begin : g_sync
         always_ff @(posedge clk_eff) begin
            if (rst == !CLK_INFO.active_low) q <= RESET_VALUE;
            else if (en)                     q <= d;
         end
      end
   endgenerate

endmodule

// File: rtl/std_flow_stage.sv
// Two-entry skid buffer: registered in_ready, one-cycle latency, full throughput.
module std_flow_stage
   import std_pkg::*;
#(
   parameter type T = logic
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  T           in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output T           out_data,
   output logic [1:0] occupancy
);

   std_flow_state_t state_q, state_d;
   logic            in_ready_q, in_ready_d;
   T                main_q, main_d;
   T                skid_q, skid_d;
   logic            main_en, skid_en;
   logic            in_xfer, out_xfer;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = 2'(state_q);

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid & out_ready;

   // Next state and data-path enables.
   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      main_d  = in_data;
      skid_en = 1'b0;
      skid_d  = in_data;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               main_en = 1'b1;
               state_d = HALF;
            end
         end
         HALF: begin
            if (in_xfer && out_xfer) begin
               main_en = 1'b1;
            end else if (in_xfer) begin
               skid_en = 1'b1;
               state_d = FULL;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               main_d  = skid_q;
               main_en = 1'b1;
               state_d = HALF;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Computed from next state so in_ready never sees out_ready combinationally.
      in_ready_d = (state_d != FULL);
   end

   std_register #(
      .T           (std_flow_state_t),
      .CLK_INFO    (STD_CLOCK_INFO_ASYNC_LOW),
      .RESET_VALUE (EMPTY)
   ) u_state (
      .clk (clk), .rst (rst), .en (1'b1), .d (state_d), .q (state_q)
   );

   std_register #(
      .T           (logic),
      .CLK_INFO    (STD_CLOCK_INFO_ASYNC_LOW),
      .RESET_VALUE (1'b0)
   ) u_in_ready (
      .clk (clk), .rst (rst), .en (1'b1), .d (in_ready_d), .q (in_ready_q)
   );

   std_register #(
      .T           (T),
      .CLK_INFO    (STD_CLOCK_INFO_ASYNC_LOW),
      .RESET_VALUE (T'(0))
   ) u_main (
      .clk (clk), .rst (rst), .en (main_en), .d (main_d), .q (main_q)
   );

   std_register #(
      .T           (T),
      .CLK_INFO    (STD_CLOCK_INFO_ASYNC_LOW),
      .RESET_VALUE (T'(0))
   ) u_skid (
      .clk (clk), .rst (rst), .en (skid_en), .d (skid_d), .q (skid_q)
   );

endmodule

// File: tb/tb_std_flow_stage.sv
// Directed and randomized checks of the std_flow_stage skid buffer.
module tb_std_flow_stage;

   typedef logic [7:0] byte_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   byte_t      in_data;
   logic       out_valid;
   logic       out_ready;
   byte_t      out_data;
   logic [1:0] occupancy;

   int total = 0;
   int bad   = 0;

   std_flow_stage #(.T(byte_t)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   byte_t q[$];
   byte_t exp_b;
   int    m_occ;
   int    sent;
   int    cycles;
   logic  ir1, ir2, ix, ox;

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      step();
      step();
      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_occ",       32'(occupancy), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'h00);

      // Release; in_ready comes up on the first edge, first payload on the next
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      step();
      chk("rel_in_ready",  32'(in_ready),  32'd1);
      chk("rel_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("a5_out_valid", 32'(out_valid), 32'd1);
      chk("a5_out_data",  32'(out_data),  32'hA5);
      chk("a5_occ",       32'(occupancy), 32'd1);
      in_valid = 1'b0;
      step();
      chk("a5_drain_occ", 32'(occupancy), 32'd0);

      // Streaming at full rate
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1; in_data = byte_t'(i); out_ready = 1'b1;
         step();
         chk("stream_data", 32'(out_data),  32'(i));
         chk("stream_occ",  32'(occupancy), 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_end_occ", 32'(occupancy), 32'd0);

      // Backpressure to FULL, offer while FULL, then drain
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
      step();
      in_data = 8'h22;
      step();
      chk("full_occ",      32'(occupancy), 32'd2);
      chk("full_in_ready", 32'(in_ready),  32'd0);
      chk("full_data",     32'(out_data),  32'h11);
      in_data = 8'h33;
      step();
      step();
      chk("full_hold_data", 32'(out_data),  32'h11);
      chk("full_hold_occ",  32'(occupancy), 32'd2);
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      step();
      chk("drain1_data",     32'(out_data),  32'h22);
      chk("drain1_in_ready", 32'(in_ready),  32'd1);
      chk("drain1_occ",      32'(occupancy), 32'd1);
      step();
      chk("drain2_occ",   32'(occupancy), 32'd0);
      chk("drain2_valid", 32'(out_valid), 32'd0);

      // Reset asserted mid-cycle while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
      step();
      in_data = 8'h55;
      step();
      chk("pre_rst_occ", 32'(occupancy), 32'd2);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_valid",    32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready),  32'd0);
      chk("mid_rst_occ",      32'(occupancy), 32'd0);
      chk("mid_rst_data",     32'(out_data),  32'h00);
      step();
      rst = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_valid", 32'(out_valid), 32'd0);
      end

      // Randomized traffic against a FIFO scoreboard
      m_occ = 0; sent = 0; cycles = 0;
      while ((sent < 10000 || m_occ != 0) && cycles < 60000) begin
         chk("rnd_in_ready",  32'(in_ready),  32'(m_occ != 2));
         chk("rnd_out_valid", 32'(out_valid), 32'(m_occ != 0));
         in_valid  = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data   = byte_t'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         #1 ir1 = in_ready;
         out_ready = ~out_ready;
         #1 ir2 = in_ready;
         out_ready = ~out_ready;
         if (ir1 !== ir2) chk("rnd_ready_indep", 32'(ir2), 32'(ir1));
         ix = in_valid && (m_occ != 2);
         ox = out_ready && (m_occ != 0);
         if (ox) begin
            exp_b = q.pop_front();
            chk("rnd_out_data", 32'(out_data), 32'(exp_b));
         end
         if (ix) begin
            q.push_back(in_data);
            sent++;
         end
         m_occ = m_occ + int'(ix) - int'(ox);
         cycles++;
         @(posedge clk);
         #1;
      end
      chk("rnd_budget",   32'(cycles < 60000), 32'd1);
      chk("rnd_sent",     32'(sent),           32'd10000);
      chk("rnd_final_occ", 32'(occupancy),     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
